// File: rtl/mem_block_fifo.sv
// First-word-fall-through block FIFO with occupancy count and peak-occupancy tracking.
// Status flags come from the registered count only, so ready/valid never loop back combinationally.
module mem_block_fifo #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [BLOCK_W-1:0] block_out,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   high_water,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BLOCK_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]    r_wr_ptr;
  logic [PtrW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_high_water;

  logic [PtrW-1:0]    w_wr_ptr_d;
  logic [PtrW-1:0]    w_rd_ptr_d;
  logic [CNT_W-1:0]   w_count_d;
  logic [CNT_W-1:0]   w_high_water_d;
  logic               w_push;
  logic               w_pop;

  always_comb begin
    full     = (r_count == CNT_W'(DEPTH));
    empty    = (r_count == '0);
    wr_ready = !full;
    rd_valid = !empty;
  end

  // Flush wins over both sides, so neither handshake completes in a flush cycle.
  always_comb begin
    w_push = wr_valid && wr_ready && !flush;
    w_pop  = rd_valid && rd_ready && !flush;
  end

  always_comb begin
    w_wr_ptr_d     = r_wr_ptr;
    w_rd_ptr_d     = r_rd_ptr;
    w_count_d      = r_count;
    w_high_water_d = r_high_water;
    if (flush) begin
      w_wr_ptr_d     = '0;
      w_rd_ptr_d     = '0;
      w_count_d      = '0;
      w_high_water_d = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_d = r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_d = r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + CNT_W'(1);
        2'b01:   w_count_d = r_count - CNT_W'(1);
        default: w_count_d = r_count;
      endcase
      if (w_count_d > r_high_water) begin
        w_high_water_d = w_count_d;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_high_water <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_d;
      r_rd_ptr     <= w_rd_ptr_d;
      r_count      <= w_count_d;
      r_high_water <= w_high_water_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= block_in;
    end
  end

  // Stale entries survive a flush; masking on empty keeps them off the output.
  always_comb begin
    block_out  = empty ? '0 : r_mem[r_rd_ptr];
    count      = r_count;
    high_water = r_high_water;
  end

endmodule

// File: tb/tb_mem_block_fifo.sv
// Directed self-checking bench for mem_block_fifo at default parameters (128-bit, depth 4).
module tb_mem_block_fifo;

  logic         CLK;
  logic         RST;
  logic         flush;
  logic         wr_valid;
  logic         wr_ready;
  logic [127:0] block_in;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] block_out;
  logic [2:0]   count;
  logic [2:0]   high_water;
  logic         full;
  logic         empty;

  int total = 0;
  int bad   = 0;

  mem_block_fifo dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .block_in   (block_in),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .block_out  (block_out),
    .count      (count),
    .high_water (high_water),
    .full       (full),
    .empty      (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [2:0] exp_cnt,
                              input logic [2:0] exp_hw, input logic [127:0] exp_out);
    check({tag, ".count"}, 128'(count), 128'(exp_cnt));
    check({tag, ".high_water"}, 128'(high_water), 128'(exp_hw));
    check({tag, ".block_out"}, block_out, exp_out);
    check({tag, ".empty"}, 128'(empty), 128'(exp_cnt == 3'd0));
    check({tag, ".full"}, 128'(full), 128'(exp_cnt == 3'd4));
    check({tag, ".rd_valid"}, 128'(rd_valid), 128'(exp_cnt != 3'd0));
    check({tag, ".wr_ready"}, 128'(wr_ready), 128'(exp_cnt != 3'd4));
  endtask

  initial begin
    RST      = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    block_in = '0;

    step();
    step();
    check_status("reset", 3'd0, 3'd0, 128'h0);
    RST = 1'b0;

    // Single push, visible one cycle later; then drain it.
    wr_valid = 1'b1;
    block_in = 128'h1;
    step();
    wr_valid = 1'b0;
    check_status("push1", 3'd1, 3'd1, 128'h1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_status("pop1", 3'd0, 3'd1, 128'h0);

    // Fill with A..D, then offer E while full.
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      block_in = 128'hA + 128'(i);
      step();
    end
    check_status("fill", 3'd4, 3'd4, 128'hA);
    block_in = 128'hE;
    step();
    wr_valid = 1'b0;
    check_status("push_full", 3'd4, 3'd4, 128'hA);

    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), block_out, 128'hA + 128'(i));
      step();
    end
    rd_ready = 1'b0;
    check_status("drained", 3'd0, 3'd4, 128'h0);

    // Pop while empty has no effect.
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_status("pop_empty", 3'd0, 3'd4, 128'h0);

    // Preload two, then stream push+pop for 10 cycles across pointer wraps.
    wr_valid = 1'b1;
    block_in = 128'h100;
    step();
    block_in = 128'h101;
    step();
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      block_in = 128'h102 + 128'(i);
      check($sformatf("stream_out%0d", i), block_out, 128'h100 + 128'(i));
      step();
      check($sformatf("stream_cnt%0d", i), 128'(count), 128'd2);
    end
    rd_ready = 1'b0;
    check_status("stream_end", 3'd2, 3'd4, 128'h10A);

    // Fill, then push+pop while full: only the pop takes effect.
    block_in = 128'h200;
    step();
    block_in = 128'h201;
    step();
    check_status("refill", 3'd4, 3'd4, 128'h10A);
    block_in = 128'h2FF;
    rd_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_status("full_pushpop", 3'd3, 3'd4, 128'h10B);

    // Flush with a concurrent push and pop offered.
    flush    = 1'b1;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    block_in = 128'h3EE;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_status("flush", 3'd0, 3'd0, 128'h0);

    wr_valid = 1'b1;
    block_in = 128'h400;
    step();
    block_in = 128'h401;
    step();
    wr_valid = 1'b0;
    check_status("post_flush", 3'd2, 3'd2, 128'h400);

    // Asynchronous reset between edges.
    #3;
    RST = 1'b1;
    #1;
    check_status("async_rst", 3'd0, 3'd0, 128'h0);
    #2;
    RST      = 1'b0;
    wr_valid = 1'b1;
    block_in = 128'h500;
    step();
    wr_valid = 1'b0;
    check_status("post_rst", 3'd1, 3'd1, 128'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_block_fifo.md
MEM_BLOCK_FIFO -- requirements
Module: mem_block_fifo

Interface
REQ-001 Parameter BLOCK_W, default 128, width in bits of one stored message block.
REQ-002 Parameter DEPTH, default 4, number of block entries; legal values are powers of two, 2..64.
REQ-003 Parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy outputs.
REQ-004 CLK  input  1  the single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all queued blocks.
REQ-007 wr_valid  input  1  producer offers block_in this cycle.
REQ-008 wr_ready  output  1  buffer can accept a block this cycle.
REQ-009 block_in  input  BLOCK_W  block to store.
REQ-010 rd_valid  output  1  block_out holds a valid head block.
REQ-011 rd_ready  input  1  consumer takes the head block this cycle.
REQ-012 block_out  output  BLOCK_W  oldest stored block (first-word-fall-through).
REQ-013 count  output  CNT_W  current number of stored blocks.
REQ-014 high_water  output  CNT_W  peak value of count since the last reset or flush.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.

Function
REQ-017 Push occurs on a rising edge when wr_valid && wr_ready; block_in is written at the write pointer, which then advances by one modulo DEPTH.
REQ-018 Pop occurs on a rising edge when rd_valid && rd_ready; the read pointer then advances by one modulo DEPTH.
REQ-019 wr_ready SHALL equal !full; a push attempted while full is refused and block_in is not stored, even if a pop happens in the same cycle.
REQ-020 rd_valid SHALL equal !empty; rd_ready while empty has no effect.
REQ-021 block_out SHALL equal the entry at the read pointer when !empty, and all zeros when empty, with zero-cycle latency from the pointer update.
REQ-022 A block pushed at edge N SHALL be visible on block_out with rd_valid high after edge N if the buffer was empty, i.e. 1-cycle write-to-read latency.
REQ-023 Push and pop in the same cycle: count unchanged; both pointers advance.
REQ-024 count SHALL increase by 1 on push-only, decrease by 1 on pop-only, and never exceed DEPTH or go below 0.
REQ-025 high_water SHALL update to the next count whenever the next count exceeds the current high_water.
REQ-026 flush SHALL, on the next edge, zero both pointers, count and high_water; it takes precedence over a push or pop in the same cycle, and no block is accepted or delivered in that cycle.
REQ-027 Stored entry contents are not cleared by flush, but block_out SHALL read zero because empty is asserted.
REQ-028 Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers SHALL return to 0 and the order of blocks is preserved across the wrap.
REQ-029 full, empty, wr_ready and rd_valid SHALL be derived from registered count only, with no combinational path from wr_valid or rd_ready.

Reset
REQ-030 While RST is high, asynchronously: pointers, count and high_water = 0; all entries = 0; empty = 1, full = 0, wr_ready = 1, rd_valid = 0, block_out = 0.
REQ-031 RST asserted mid-operation SHALL discard all queued blocks; the first edge after deassertion may accept a push.

Verification
REQ-032 Reset, then push 128'h1 -> next cycle rd_valid = 1, block_out = 128'h1, count = 1, high_water = 1.
REQ-033 Push 128'hA, B, C, D with no pops -> full = 1, wr_ready = 0; a 5th push of 128'hE is refused; pops return A, B, C, D in order, then empty = 1 and block_out = 0.
REQ-034 With count = 2, push and pop simultaneously for 10 cycles -> count stays 2, pointers wrap, and output order matches input order.
REQ-035 Full buffer, wr_valid = 1 and rd_ready = 1 in the same cycle -> pop occurs, push refused, count = 3.
REQ-036 With count = 3 and high_water = 4, assert flush with wr_valid = 1 -> next cycle count = 0, high_water = 0, empty = 1, and the offered block is not stored.
REQ-037 Assert RST asynchronously between edges with count = 2 -> outputs reach their reset values immediately, before the next edge.
